cpu_seq: RTL

CPU_SEQ -- requirements
Module: cpu_seq

---
 rtl/cpu_seq_pkg.sv | 31 +++
 rtl/cpu_seq_wdt.sv | 30 +++
 rtl/cpu_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types for the instruction sequencer: FSM state and halt-cause encodings.
package cpu_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CAUSE_W = 3;

    // Encodings are fixed because debug tooling decodes o_state / o_halt_cause directly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_EBREAK   = 3'd1,
        CAUSE_DEC_ERR  = 3'd2,
        CAUSE_TIMEOUT  = 3'd3,
        CAUSE_MISALIGN = 3'd4
    } cause_t;

    // Width needed to count up to the timeout limit; never narrower than one bit.
    function automatic int unsigned wdt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cpu_seq_wdt.sv
// Bus wait timer: counts stalled cycles while enabled, flags the last allowed cycle.
module cpu_seq_wdt
    import cpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned W       = wdt_width(TIMEOUT);
    localparam bit          ARMED   = (TIMEOUT != 0);
    localparam logic [W-1:0] LIMIT  = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [W-1:0] count;

    // Wait-cycle counter; clear has priority so an ack restarts the count.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = ARMED && enable && (count == LIMIT);

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back, halt.
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int unsigned          CPU_WIDTH = 64,
    parameter int unsigned          INS_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RST_PC    = CPU_WIDTH'(64'h8000_0000),
    parameter int unsigned          TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_req,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [INS_WIDTH-1:0] i_imem_rdata,
    output logic                 o_dmem_req,
    output logic                 o_dmem_wen,
    input  logic                 i_dmem_ack,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic                 i_is_ebreak,
    input  logic                 i_dec_err,
    input  logic                 i_rdwen,
    input  logic [CPU_WIDTH-1:0] i_next_pc,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic [INS_WIDTH-1:0] o_ins,
    output logic                 o_rf_wen,
    output logic                 o_halt,
    output logic [2:0]           o_halt_cause,
    output logic [CPU_WIDTH-1:0] o_retired,
    output logic [2:0]           o_state
);

    state_t                 state, state_nx;
    cause_t                 cause, cause_nx;
    logic [CPU_WIDTH-1:0]   pc;
    logic [CPU_WIDTH-1:0]   retired;
    logic [INS_WIDTH-1:0]   ins;

    logic waiting;
    logic ack;
    logic wait_clr;
    logic tmo;
    logic misaligned;

    // Only the ack belonging to the current request state counts.
    assign waiting    = (state == ST_FETCH) || (state == ST_MEM);
    assign ack        = ((state == ST_FETCH) && i_imem_ack) || ((state == ST_MEM) && i_dmem_ack);
    // Holding the timer clear outside the wait states makes every entry start from zero.
    assign wait_clr   = i_rst || !waiting || ack;
    assign misaligned = |i_next_pc[1:0];

    cpu_seq_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (i_clk),
        .clear   (wait_clr),
        .enable  (waiting),
        .timeout (tmo)
    );

    // State and halt-cause register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cause <= CAUSE_NONE;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
        end
    end

    // Next-state, halt cause and per-state strobes.
    always_comb begin
        state_nx   = state;
        cause_nx   = cause;
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_wen = 1'b0;
        o_rf_wen   = 1'b0;
        o_halt     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    state_nx = ST_DECODE;
                end else if (tmo) begin
                    state_nx = ST_HALT;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (i_is_ebreak) begin
                    state_nx = ST_HALT;
                    cause_nx = CAUSE_EBREAK;
                end else if (i_dec_err) begin
                    state_nx = ST_HALT;
                    cause_nx = CAUSE_DEC_ERR;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nx = (i_is_load || i_is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_wen = i_is_store;
                if (i_dmem_ack) begin
                    state_nx = ST_WB;
                end else if (tmo) begin
                    state_nx = ST_HALT;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                o_rf_wen = i_rdwen;
                if (misaligned) begin
                    state_nx = ST_HALT;
                    cause_nx = CAUSE_MISALIGN;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_HALT: begin
                o_halt = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Architectural registers: PC, latched instruction, retire counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc      <= RST_PC;
            ins     <= '0;
            retired <= '0;
        end else begin
            if ((state == ST_FETCH) && i_imem_ack) begin
                ins <= i_imem_rdata;
            end
            if (state == ST_WB) begin
                retired <= retired + 1'b1;
                if (!misaligned) begin
                    pc <= i_next_pc;
                end
            end
        end
    end

    assign o_pc         = pc;
    assign o_imem_addr  = pc;
    assign o_ins        = ins;
    assign o_retired    = retired;
    assign o_halt_cause = cause;
    assign o_state      = state;

endmodule
